seq_addsub: RTL and testbench
=============================

SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits processed per cycle; WIDTH mod CHUNK SHALL be 0, and N = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to begin an operation.
REQ-006 sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 cin  input  1  carry-in, used in add mode only.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when result is valid.
REQ-012 result  output  WIDTH  sum or difference.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; reset SHALL force IDLE.
REQ-016 start SHALL be accepted when it is high on an edge where the state is IDLE or DONE; on acceptance a, b, sub and cin SHALL be latched and the state SHALL go to RUN.
REQ-017 start SHALL be ignored while in RUN; latched operands SHALL NOT change.
REQ-018 Each RUN cycle SHALL add one CHUNK-bit slice, LSB slice first, using the carry from the previous slice; slice index SHALL count 0..N-1.
REQ-019 Add mode: initial carry = latched cin; operand B = b.
REQ-020 Subtract mode: initial carry = 1, cin ignored; operand B = ~b, so result = a - b mod 2^WIDTH.
REQ-021 After slice N-1 is processed, the state SHALL go to DONE for exactly one cycle and then to IDLE, unless start is accepted in DONE.
REQ-022 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE.
REQ-023 Latency: for start accepted at edge k, done SHALL be high in the cycle following edge k+N; busy SHALL be high for N cycles.
REQ-024 cout SHALL equal the final carry out of bit WIDTH-1; in subtract mode, cout = 1 means no borrow.
REQ-025 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-026 result, cout and ovf SHALL hold their last values from DONE through IDLE until the next accepted operation completes; partial slices MAY be visible while busy.
REQ-027 A back-to-back start accepted in DONE SHALL begin RUN on the next cycle with no idle cycle, while done still pulses for the previous result.

Reset
REQ-028 On rst high at an edge, the block SHALL enter IDLE and set busy=0, done=0, result=0, cout=0, ovf=0 and slice index=0, including mid-RUN.
REQ-029 rst SHALL take priority over start on the same edge.
REQ-030 An aborted operation SHALL NOT produce a done pulse.

Structure
REQ-031 State encodings (IDLE=0, RUN=1, DONE=2) SHALL live in a shared package, seq_addsub_pkg, as localparams.
REQ-032 One sub-module, rca_chunk, SHALL be parametrised by CHUNK and SHALL provide a combinational ripple adder outputting sum, carry-out and carry-into-MSB; it SHALL be instantiated once.

Verification (WIDTH=8, CHUNK=4)
REQ-033 Add 0x7F + 0x01, cin=0 -> result 0x80, cout=0, ovf=1; done exactly 2 cycles after the accept edge.
REQ-034 Subtract 0x05 - 0x07 -> result 0xFE, cout=0, ovf=0; subtract 0x80 - 0x01 -> result 0x7F, cout=1, ovf=1.
REQ-035 Add 0xFF + 0x00, cin=1 -> result 0x00, cout=1, ovf=0; checks carry propagating across the slice boundary.
REQ-036 Drive start with new operands during RUN -> ignored; original result reported; exactly one done pulse.
REQ-037 Assert rst during the first RUN cycle -> next cycle shows IDLE, busy=0, result=0, and no done pulse follows.
REQ-038 Hold start high continuously with changing operands -> operations run back to back, done pulses every N+1 cycles, and every result matches the reference model.

Source files
------------

// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg: shared definitions for the sequential chunked adder/subtractor.
//   ST_IDLE/ST_RUN/ST_DONE : state encodings (0/1/2)
//   state_t                : FSM state type built on those encodings
//   idx_bits()             : width of the slice index for a given slice count
package seq_addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // At least one bit so a single-slice configuration still has a legal index.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_if.sv
// seq_addsub_if: request/result bundle of seq_addsub.
//   start, sub, a, b, cin           : request (driven by master)
//   busy, done, result, cout, ovf   : status/result (driven by slave)
interface seq_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/seq_addsub_rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple-carry adder.
//   a, b  : slice operands      cin  : carry into bit 0
//   sum   : slice sum           cout : carry out of the MSB
//   cmsb  : carry into the MSB (for signed overflow detection)
module rca_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: sequential adder/subtractor processing CHUNK bits per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_addsub_if.slave (start/sub/a/b/cin in; busy/done/result/cout/ovf out)
// An operation takes WIDTH/CHUNK RUN cycles followed by one DONE cycle;
// a start seen in DONE chains the next operation with no idle gap.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic clk,
  input  logic rst,
  seq_addsub_if.slave bus
);
  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned IW = idx_bits(N);

  state_t           state_q, state_d;
  logic             accept, last;
  logic             busy, done;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IW-1:0]    idx_q;
  logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout, sl_cmsb;

  assign last = (idx_q == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Current slice of the latched operands; b_q already holds ~b in subtract mode.
  always_comb begin
    sl_a = a_q[CHUNK*idx_q +: CHUNK];
    sl_b = b_q[CHUNK*idx_q +: CHUNK];
  end

  rca_chunk #(.CHUNK(CHUNK)) u_rca (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout),
    .cmsb (sl_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub ? 1'b1 : bus.cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      // result is built in place; earlier slices overwrite the previous result
      res_q[CHUNK*idx_q +: CHUNK] <= sl_sum;
      carry_q <= sl_cout;
      idx_q   <= idx_q + IW'(1);
      if (last) begin
        cout_q <= sl_cout;
        ovf_q  <= sl_cmsb ^ sl_cout;
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: self-checking bench for seq_addsub (WIDTH=8, CHUNK=4).
// A cycle-level reference model predicts busy/done and the held result;
// a negedge compare process checks the DUT against it every cycle, and
// directed operations pin both DUT and model to hand-computed values.
module tb_seq_addsub;
  localparam int unsigned W = 8;
  localparam int unsigned C = 4;
  localparam int unsigned N = W / C;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   done_cnt = 0;
  bit   cmp_en = 0;

  seq_addsub_if #(.WIDTH(W)) bus ();

  seq_addsub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {ovf, cout, result} from plain arithmetic on the operands.
  function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic s, input logic c);
    logic [7:0] bb;
    logic [8:0] t;
    logic       v;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {8'd0, (s ? 1'b1 : c)};
    v  = (a[7] == bb[7]) && (t[7] != a[7]);
    return {v, t};
  endfunction

  int         m_run  = 0;   // RUN cycles still to go
  logic       m_done = 1'b0;
  logic [9:0] m_pend = '0;
  logic [9:0] m_held = '0;

  always @(posedge clk) begin
    logic acc, nd;
    cyc++;
    if (rst) begin
      m_run  = 0;
      m_done = 1'b0;
      m_held = '0;
    end else begin
      acc = bus.start && (m_run == 0);
      nd  = 1'b0;
      if (m_run > 0) begin
        m_run--;
        if (m_run == 0) begin
          nd     = 1'b1;
          m_held = m_pend;
        end
      end
      if (acc) begin
        m_run  = N;
        m_pend = ref_op(bus.a, bus.b, bus.sub, bus.cin);
      end
      m_done = nd;
    end
  end

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (cmp_en) begin
      chk("model busy", bus.busy, (m_run > 0));
      chk("model done", bus.done, m_done);
      if (m_run == 0) begin
        chk("model result", bus.result, m_held[7:0]);
        chk("model cout", bus.cout, m_held[8]);
        chk("model ovf", bus.ovf, m_held[9]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(output int lat);
    bit found;
    found = 0;
    lat   = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done === 1'b1) found = 1;
    end
    if (!found) chk("done timeout", 0, 1);
  endtask

  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic c,
                        input logic [7:0] er, input logic ec, input logic ev);
    int lat;
    @(posedge clk); #1;
    bus.a = a; bus.b = b; bus.sub = s; bus.cin = c; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    chk({nm, " latency"}, lat, N);
    chk({nm, " result"}, bus.result, er);
    chk({nm, " cout"}, bus.cout, ec);
    chk({nm, " ovf"}, bus.ovf, ev);
    chk({nm, " model"}, m_held, {ev, ec, er});
  endtask

  logic [7:0] b2b_a [6] = '{8'h7F, 8'h05, 8'hFF, 8'h80, 8'h3C, 8'hA5};
  logic [7:0] b2b_b [6] = '{8'h01, 8'h07, 8'h00, 8'h01, 8'hC4, 8'h5A};
  logic       b2b_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       b2b_c [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int snap, lat;
    int dtimes[$];
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset result", bus.result, 0);
    chk("reset cout", bus.cout, 0);
    chk("reset ovf", bus.ovf, 0);
    cmp_en = 1;
    @(posedge clk); #1 rst = 1'b0;

    run_op("add 7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub 05-07", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_op("sub 80-01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    run_op("add ff+00+1", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("sub cin ignored", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);

    // start with new operands during RUN must be ignored
    @(posedge clk); #1;
    bus.a = 8'h12; bus.b = 8'h34; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    snap = done_cnt;
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    chk("run-start result", bus.result, 8'h46);
    chk("run-start cout", bus.cout, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("run-start one done", done_cnt - snap, 1);

    // reset during the first RUN cycle aborts with no done
    @(posedge clk); #1;
    bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; rst = 1'b1;
    snap = done_cnt;
    @(posedge clk);
    @(negedge clk);
    chk("abort busy", bus.busy, 0);
    chk("abort result", bus.result, 0);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("abort no done", done_cnt - snap, 0);

    // reset wins over start on the same edge
    @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    chk("rst priority busy", bus.busy, 0);
    #1 rst = 1'b0; bus.start = 1'b0;
    repeat (2) @(posedge clk);

    // start held high with operands changing every cycle
    @(posedge clk); #1;
    bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.a = b2b_a[i % 6]; bus.b = b2b_b[i % 6];
      bus.sub = b2b_s[i % 6]; bus.cin = b2b_c[i % 6];
      @(negedge clk);
      if (bus.done === 1'b1) dtimes.push_back(cyc);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("b2b done count", (dtimes.size() >= 5), 1);
    for (int i = 1; i < dtimes.size(); i++)
      chk("b2b done period", dtimes[i] - dtimes[i-1], N + 1);
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
